sreg_univ: RTL and testbench

Parametrised universal shift register. It is the successor to the fixed-function preset/shift register in the datapath library. It adds left/right shift, rotate, parallel load, asynchronous active-low reset, and an autonomous N-bit serializer with a BUSY/DONE handshake. It sits in the datapath group, feeding serial links and bit-serial arithmetic from parallel operands.

---
 rtl/sreg_pkg.sv | 18 +
 rtl/sreg_ser_ctl.sv | 69 ++++++
 rtl/sreg_univ.sv | 80 ++++++++
 tb/tb_sreg_univ.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sreg_pkg.sv
// Shared definitions for the universal shift register: MODE codes and
// serializer FSM state encoding.
package sreg_pkg;

  localparam logic [2:0] SR_HOLD = 3'b000;
  localparam logic [2:0] SR_SHL  = 3'b001;
  localparam logic [2:0] SR_SHR  = 3'b010;
  localparam logic [2:0] SR_ROL  = 3'b011;
  localparam logic [2:0] SR_ROR  = 3'b100;
  localparam logic [2:0] SR_LOAD = 3'b101;
  localparam logic [2:0] SR_SER  = 3'b110;

  typedef enum logic {
    SR_IDLE   = 1'b0,
    SR_SER_ST = 1'b1
  } sreg_state_e;

endpackage

// File: rtl/sreg_ser_ctl.sv
// Serializer control for sreg_univ: FSM, bit counter, BUSY and DONE, plus the
// shift/load strobes that steer the data register in the top level.
module sreg_ser_ctl
  import sreg_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        pre,
  input  logic        en,
  input  logic [2:0]  mode,
  output logic        busy,
  output logic        done,
  output logic        shift_stb,
  output logic        load_stb,
  output sreg_state_e state_dbg
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  sreg_state_e   state;
  logic [CW-1:0] cnt;

  // Handshake: a start (EN=1, MODE=SER) is taken only while BUSY=0; BUSY then
  // stays high for exactly N cycles and DONE pulses for the single cycle after
  // the last bit. DONE and a new start may coincide for gapless streaming.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state <= SR_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pre) begin
        state <= SR_IDLE;
        cnt   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          SR_IDLE: begin
            if (en && (mode == SR_SER)) begin
              state <= SR_SER_ST;
              cnt   <= '0;
              busy  <= 1'b1;
            end
          end
          SR_SER_ST: begin
            if (cnt == LAST) begin
              state <= SR_IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign shift_stb = (state == SR_SER_ST) && !pre;
  assign load_stb  = (state == SR_IDLE) && !pre && en && (mode == SR_SER);
  assign state_dbg = state;

endmodule

// File: rtl/sreg_univ.sv
// Parametrised universal shift register: shifts, rotates, parallel load and an
// autonomous MSB-first serializer with BUSY/DONE.
module sreg_univ
  import sreg_pkg::*;
#(
  parameter int           N          = 8,
  parameter logic [N-1:0] RESET_VAL  = {N{1'b0}},
  parameter logic [N-1:0] PRESET_VAL = {N{1'b1}}
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         PRE,
  input  logic         EN,
  input  logic [2:0]   MODE,
  input  logic         LSBIN,
  input  logic         MSBIN,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         SOUT_L,
  output logic         SOUT_R,
  output logic         BUSY,
  output logic         DONE
);

  logic [N-1:0] q_r;
  logic [N-1:0] q_nxt;
  logic         shift_stb;
  logic         load_stb;
  sreg_state_e  ser_state;

  sreg_ser_ctl #(.N(N)) u_ser_ctl (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .pre       (PRE),
    .en        (EN),
    .mode      (MODE),
    .busy      (BUSY),
    .done      (DONE),
    .shift_stb (shift_stb),
    .load_stb  (load_stb),
    .state_dbg (ser_state)
  );

  // The serializer owns the register while active; MODE only acts when idle.
  always_comb begin
    q_nxt = q_r;
    if (shift_stb) begin
      q_nxt = {q_r[N-2:0], LSBIN};
    end else if (load_stb) begin
      q_nxt = D;
    end else if (EN) begin
      case (MODE)
        SR_SHL:  q_nxt = {q_r[N-2:0], LSBIN};
        SR_SHR:  q_nxt = {MSBIN, q_r[N-1:1]};
        SR_ROL:  q_nxt = {q_r[N-2:0], q_r[N-1]};
        SR_ROR:  q_nxt = {q_r[0], q_r[N-1:1]};
        SR_LOAD: q_nxt = D;
        default: q_nxt = q_r;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_r <= RESET_VAL;
    end else if (PRE) begin
      q_r <= PRESET_VAL;
    end else begin
      q_r <= q_nxt;
    end
  end

  assign Q      = q_r;
  assign SOUT_L = q_r[N-1];
  assign SOUT_R = q_r[0];

  a_busy_tracks_state: assert property (@(posedge CLK) disable iff (!RSTN)
    BUSY == (ser_state == SR_SER_ST));

endmodule

// File: tb/tb_sreg_univ.sv
// Directed bench for sreg_univ at N=8, N=2 and N=13: vector table for the
// mode mux, hand-written sequences for serialize, abort and reset corners.
module tb_sreg_univ;
  import sreg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  // ---------------- DUT signals (index 0: N=8, 1: N=2, 2: N=13) ----------------
  logic [2:0]        pre_v, en_v, lsb_v, msb_v;
  logic [2:0][2:0]   mode_p;
  logic [2:0][15:0]  d_p;
  logic [7:0]        q8;
  logic [1:0]        q2;
  logic [12:0]       q13;
  logic [2:0]        soutl_v, soutr_v, busy_v, done_v;

  sreg_univ #(.N(8)) u_n8 (
    .CLK(clk), .RSTN(rstn), .PRE(pre_v[0]), .EN(en_v[0]), .MODE(mode_p[0]),
    .LSBIN(lsb_v[0]), .MSBIN(msb_v[0]), .D(d_p[0][7:0]), .Q(q8),
    .SOUT_L(soutl_v[0]), .SOUT_R(soutr_v[0]), .BUSY(busy_v[0]), .DONE(done_v[0])
  );
  sreg_univ #(.N(2)) u_n2 (
    .CLK(clk), .RSTN(rstn), .PRE(pre_v[1]), .EN(en_v[1]), .MODE(mode_p[1]),
    .LSBIN(lsb_v[1]), .MSBIN(msb_v[1]), .D(d_p[1][1:0]), .Q(q2),
    .SOUT_L(soutl_v[1]), .SOUT_R(soutr_v[1]), .BUSY(busy_v[1]), .DONE(done_v[1])
  );
  sreg_univ #(.N(13)) u_n13 (
    .CLK(clk), .RSTN(rstn), .PRE(pre_v[2]), .EN(en_v[2]), .MODE(mode_p[2]),
    .LSBIN(lsb_v[2]), .MSBIN(msb_v[2]), .D(d_p[2][12:0]), .Q(q13),
    .SOUT_L(soutl_v[2]), .SOUT_R(soutr_v[2]), .BUSY(busy_v[2]), .DONE(done_v[2])
  );

  // ---------------- vector table ----------------
  typedef struct packed {
    logic        pre;
    logic        en;
    logic [2:0]  mode;
    logic        lsb;
    logic        msb;
    logic [15:0] d;
    logic [7:0]  exp8;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  int n_vec  = 0;
  int n_miss = 0;
  logic [0:0] exp_q [$];

  function automatic int width_of(input int w);
    case (w)
      0:       return 8;
      1:       return 2;
      default: return 13;
    endcase
  endfunction

  function automatic logic [15:0] mask_of(input int w);
    return (16'h1 << width_of(w)) - 16'h1;
  endfunction

  function automatic logic [15:0] q_of(input int w);
    case (w)
      0:       return {8'h0, q8};
      1:       return {14'h0, q2};
      default: return {3'h0, q13};
    endcase
  endfunction

  // Behavioural reference for widths without hand-computed table values.
  function automatic logic [15:0] model_step(input logic [15:0] qm, input vec_t v, input int n);
    logic [15:0] m;
    logic [15:0] r;
    m = (16'h1 << n) - 16'h1;
    r = qm;
    if (v.pre) r = m;
    else if (v.en) begin
      case (v.mode)
        SR_SHL:  r = ((qm << 1) | {15'b0, v.lsb}) & m;
        SR_SHR:  r = (qm >> 1) | ({15'b0, v.msb} << (n - 1));
        SR_ROL:  r = ((qm << 1) | {15'b0, qm[n-1]}) & m;
        SR_ROR:  r = (qm >> 1) | ({15'b0, qm[0]} << (n - 1));
        SR_LOAD: r = v.d & m;
        default: r = qm;
      endcase
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int w, input logic p, input logic e, input logic [2:0] m,
                       input logic l, input logic ms, input logic [15:0] dd);
    pre_v[w]  = p;
    en_v[w]   = e;
    mode_p[w] = m;
    lsb_v[w]  = l;
    msb_v[w]  = ms;
    d_p[w]    = dd;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic ser_start(input int w, input logic [15:0] data, input logic lsb);
    drive(w, 1'b0, 1'b1, SR_SER, lsb, 1'b0, data);
    tick();
    drive(w, 1'b0, 1'b0, SR_HOLD, lsb, 1'b0, data);
  endtask

  // Entered in BUSY cycle 0. ign_k: cycle in which a second start is offered.
  // chain: offer the next start in the DONE cycle.
  task automatic ser_check(input int w, input logic [15:0] data, input logic lsb,
                           input int ign_k, input bit chain, input logic [15:0] nxt);
    int n;
    logic [0:0] e;
    n = width_of(w);
    for (int k = 0; k < n; k++) exp_q.push_back(data[n-1-k]);
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      chk($sformatf("n%0d busy k%0d", n, k), {15'b0, busy_v[w]}, 16'h1);
      chk($sformatf("n%0d sout_l k%0d", n, k), {15'b0, soutl_v[w]}, {15'b0, e});
      chk($sformatf("n%0d done_low k%0d", n, k), {15'b0, done_v[w]}, 16'h0);
      if (k == ign_k) drive(w, 1'b0, 1'b1, SR_SER, lsb, 1'b0, ~data);
      else            drive(w, 1'b0, 1'b0, SR_HOLD, lsb, 1'b0, data);
      tick();
    end
    chk($sformatf("n%0d busy_end", n), {15'b0, busy_v[w]}, 16'h0);
    chk($sformatf("n%0d done_pulse", n), {15'b0, done_v[w]}, 16'h1);
    chk($sformatf("n%0d q_final", n), q_of(w), lsb ? mask_of(w) : 16'h0);
    if (chain) begin
      drive(w, 1'b0, 1'b1, SR_SER, lsb, 1'b0, nxt);
      tick();
      drive(w, 1'b0, 1'b0, SR_HOLD, lsb, 1'b0, nxt);
    end else begin
      drive(w, 1'b0, 1'b0, SR_HOLD, lsb, 1'b0, 16'h0);
      tick();
      chk($sformatf("n%0d done_once", n), {15'b0, done_v[w]}, 16'h0);
      chk($sformatf("n%0d busy_idle", n), {15'b0, busy_v[w]}, 16'h0);
    end
  endtask

  task automatic ser_abort(input int w, input logic [15:0] data);
    int n;
    int k_ab;
    n = width_of(w);
    k_ab = (n > 3) ? 3 : n - 1;
    // PRE coinciding with a start request: PRE wins, no serialization
    drive(w, 1'b1, 1'b1, SR_SER, 1'b0, 1'b0, data);
    tick();
    chk($sformatf("n%0d pre_vs_start q", n), q_of(w), mask_of(w));
    chk($sformatf("n%0d pre_vs_start busy", n), {15'b0, busy_v[w]}, 16'h0);
    drive(w, 1'b0, 1'b0, SR_HOLD, 1'b0, 1'b0, data);
    ser_start(w, data, 1'b0);
    for (int k = 0; k < k_ab; k++) tick();
    chk($sformatf("n%0d busy_before_abort", n), {15'b0, busy_v[w]}, 16'h1);
    drive(w, 1'b1, 1'b0, SR_HOLD, 1'b0, 1'b0, data);
    tick();
    drive(w, 1'b0, 1'b0, SR_HOLD, 1'b0, 1'b0, data);
    chk($sformatf("n%0d abort q", n), q_of(w), mask_of(w));
    chk($sformatf("n%0d abort busy", n), {15'b0, busy_v[w]}, 16'h0);
    chk($sformatf("n%0d abort done", n), {15'b0, done_v[w]}, 16'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("n%0d post_abort done c%0d", n, k), {15'b0, done_v[w]}, 16'h0);
      chk($sformatf("n%0d post_abort q c%0d", n, k), q_of(w), mask_of(w));
    end
  endtask

  task automatic reset_mid_ser(input int w, input logic [15:0] data);
    int n;
    n = width_of(w);
    ser_start(w, data, 1'b1);
    tick();
    #2 rstn = 1'b0;
    #1;
    chk($sformatf("n%0d async_rst q", n), q_of(w), 16'h0);
    chk($sformatf("n%0d async_rst busy", n), {15'b0, busy_v[w]}, 16'h0);
    chk($sformatf("n%0d async_rst done", n), {15'b0, done_v[w]}, 16'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < n + 2; k++) begin
      tick();
      chk($sformatf("n%0d post_rst done c%0d", n, k), {15'b0, done_v[w]}, 16'h0);
      chk($sformatf("n%0d post_rst busy c%0d", n, k), {15'b0, busy_v[w]}, 16'h0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] q_m;
    logic [15:0] exp;
    logic [15:0] da [3];
    logic [15:0] db [3];
    vec_t v;
    int n;

    da = '{16'h00A5, 16'h0002, 16'h15A5};
    db = '{16'h003C, 16'h0001, 16'h0C3C};

    //              pre   en    mode     lsb   msb   d         exp8
    tbl[0]  = '{1'b0, 1'b1, SR_LOAD, 1'b0, 1'b0, 16'h0081, 8'h81};
    tbl[1]  = '{1'b0, 1'b1, SR_SHL,  1'b0, 1'b0, 16'h0000, 8'h02};
    tbl[2]  = '{1'b0, 1'b1, SR_LOAD, 1'b0, 1'b0, 16'h0081, 8'h81};
    tbl[3]  = '{1'b0, 1'b1, SR_SHR,  1'b0, 1'b1, 16'h0000, 8'hC0};
    tbl[4]  = '{1'b0, 1'b1, SR_LOAD, 1'b0, 1'b0, 16'h0081, 8'h81};
    tbl[5]  = '{1'b0, 1'b1, SR_ROL,  1'b0, 1'b0, 16'h0000, 8'h03};
    tbl[6]  = '{1'b0, 1'b1, SR_LOAD, 1'b0, 1'b0, 16'h0081, 8'h81};
    tbl[7]  = '{1'b0, 1'b1, SR_ROR,  1'b0, 1'b0, 16'h0000, 8'hC0};
    tbl[8]  = '{1'b0, 1'b0, SR_SHL,  1'b1, 1'b0, 16'h0000, 8'hC0};
    tbl[9]  = '{1'b0, 1'b1, 3'b111,  1'b1, 1'b1, 16'h0055, 8'hC0};
    tbl[10] = '{1'b0, 1'b1, SR_HOLD, 1'b1, 1'b1, 16'h0055, 8'hC0};
    tbl[11] = '{1'b1, 1'b1, SR_LOAD, 1'b0, 1'b0, 16'h0012, 8'hFF};
    tbl[12] = '{1'b0, 1'b1, SR_SHL,  1'b1, 1'b0, 16'h0000, 8'hFF};
    tbl[13] = '{1'b0, 1'b1, SR_SHR,  1'b0, 1'b0, 16'h0000, 8'h7F};
    tbl[14] = '{1'b0, 1'b1, SR_LOAD, 1'b0, 1'b0, 16'h005A, 8'h5A};
    tbl[15] = '{1'b0, 1'b1, SR_ROL,  1'b0, 1'b0, 16'h0000, 8'hB4};
    tbl[16] = '{1'b0, 1'b1, SR_ROR,  1'b0, 1'b0, 16'h0000, 8'h5A};
    tbl[17] = '{1'b0, 1'b1, SR_SHL,  1'b1, 1'b0, 16'h0000, 8'hB5};
    tbl[18] = '{1'b0, 1'b1, SR_SHR,  1'b0, 1'b1, 16'h0000, 8'hDA};

    rstn = 1'b0;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 1'b0, SR_HOLD, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      chk($sformatf("n%0d reset q", width_of(w)), q_of(w), 16'h0);
      chk($sformatf("n%0d reset busy", width_of(w)), {15'b0, busy_v[w]}, 16'h0);
      chk($sformatf("n%0d reset done", width_of(w)), {15'b0, done_v[w]}, 16'h0);
    end
    rstn = 1'b1;
    tick();

    for (int w = 0; w < 3; w++) begin
      n = width_of(w);
      q_m = 16'h0;
      for (int i = 0; i < NV; i++) begin
        v = tbl[i];
        drive(w, v.pre, v.en, v.mode, v.lsb, v.msb, v.d);
        tick();
        q_m = model_step(q_m, v, n);
        exp = (w == 0) ? {8'h0, v.exp8} : q_m;
        chk($sformatf("n%0d vec%0d q", n, i), q_of(w), exp);
        chk($sformatf("n%0d vec%0d sout_l", n, i), {15'b0, soutl_v[w]}, {15'b0, exp[n-1]});
        chk($sformatf("n%0d vec%0d sout_r", n, i), {15'b0, soutr_v[w]}, {15'b0, exp[0]});
        chk($sformatf("n%0d vec%0d busy", n, i), {15'b0, busy_v[w]}, 16'h0);
      end
      drive(w, 1'b0, 1'b0, SR_HOLD, 1'b0, 1'b0, 16'h0);

      ser_start(w, da[w], 1'b0);
      ser_check(w, da[w], 1'b0, -1, 1'b0, 16'h0);

      ser_start(w, da[w], 1'b0);
      ser_check(w, da[w], 1'b0, (n > 2) ? 2 : n - 1, 1'b0, 16'h0);

      ser_start(w, da[w], 1'b0);
      ser_check(w, da[w], 1'b0, -1, 1'b1, db[w]);
      ser_check(w, db[w], 1'b0, -1, 1'b0, 16'h0);

      ser_start(w, db[w], 1'b1);
      ser_check(w, db[w], 1'b1, -1, 1'b0, 16'h0);

      ser_abort(w, da[w]);
      reset_mid_ser(w, da[w]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
